// File: rtl/core_scheduler.sv
// -----------------------------------------------------------------------------
// core_scheduler
//
// Sequences one thread through an instruction pipeline:
//   IDLE -> FETCH -> DECODE -> REQUEST -> WAIT -> EXECUTE -> UPDATE -> FETCH/DONE
//
// Parameters
//   PC_WIDTH : width of pc / next_pc
//   TIMEOUT  : maximum wait-counter value for an LSU reply (0..255)
//
// Ports
//   clk              : clock, rising-edge
//   reset            : asynchronous active-low reset
//   start            : launch a thread (sampled in IDLE only)
//   fetch_done       : instruction fetched (sampled in FETCH only)
//   dec_mem_op       : decoded instruction is a load/store (sampled in REQUEST)
//   dec_reg_we       : decoded instruction writes the register file
//   dec_ret          : decoded instruction is RET
//   lsu_done         : LSU reply (sampled in WAIT only)
//   next_pc          : PC from the PC unit, captured in UPDATE
//   core_state       : current state code (also the FSM debug view)
//   pc               : current program counter
//   fetch_req        : fetch request, high throughout FETCH
//   lsu_req          : one-cycle LSU launch pulse in REQUEST
//   reg_write_enable : register-file write strobe in UPDATE
//   done             : thread finished
//   error            : LSU timeout seen; sticky until reset
//
// Handshakes: request/done pairs are level-sampled, not remembered. A done
// input only counts in the state that is waiting for it (fetch_done in
// FETCH, lsu_done in WAIT, start in IDLE); a pulse in any other state is
// dropped, so a responder must hold or re-issue it while the scheduler waits.
// -----------------------------------------------------------------------------
module core_scheduler #(
    parameter int PC_WIDTH = 8,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                fetch_done,
    input  logic                dec_mem_op,
    input  logic                dec_reg_we,
    input  logic                dec_ret,
    input  logic                lsu_done,
    input  logic [PC_WIDTH-1:0] next_pc,
    output logic [2:0]          core_state,
    output logic [PC_WIDTH-1:0] pc,
    output logic                fetch_req,
    output logic                lsu_req,
    output logic                reg_write_enable,
    output logic                done,
    output logic                error
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_FETCH   = 3'b001,
        S_DECODE  = 3'b010,
        S_REQUEST = 3'b011,
        S_WAIT    = 3'b100,
        S_EXECUTE = 3'b101,
        S_UPDATE  = 3'b110,
        S_DONE    = 3'b111
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       mem_pending;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            pc          <= '0;
            wait_cnt    <= '0;
            mem_pending <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) state <= S_FETCH;
                end
                S_FETCH: begin
                    if (fetch_done) state <= S_DECODE;
                end
                S_DECODE: begin
                    state <= S_REQUEST;
                end
                S_REQUEST: begin
                    // Counter is cleared here so every WAIT visit starts at 0.
                    mem_pending <= dec_mem_op;
                    wait_cnt    <= '0;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    if (!mem_pending) begin
                        state <= S_EXECUTE;
                    end else if (lsu_done) begin
                        // A reply in the timeout cycle still wins.
                        state <= S_EXECUTE;
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        error <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_EXECUTE: begin
                    state <= S_UPDATE;
                end
                S_UPDATE: begin
                    // pc always advances, RET or not; no arithmetic here.
                    pc <= next_pc;
                    if (dec_ret) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // State register doubles as the registered core_state for the regfile.
    assign core_state       = state;
    assign fetch_req        = (state == S_FETCH);
    assign lsu_req          = (state == S_REQUEST) && dec_mem_op;
    assign reg_write_enable = (state == S_UPDATE) && dec_reg_we;

endmodule

// File: doc/core_scheduler.md
CORE_SCHEDULER -- requirements
Module: core_scheduler

Parameters
REQ-001 SHALL provide PC_WIDTH, default 8, width of pc and next_pc.
REQ-002 SHALL provide TIMEOUT, default 255, maximum WAIT cycles for an LSU reply before abort.

Interface
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  launch a thread; sampled only in IDLE.
REQ-006 fetch_done  input  1  instruction fetched; sampled only in FETCH.
REQ-007 dec_mem_op  input  1  decoded instruction is a load or store; sampled in REQUEST.
REQ-008 dec_reg_we  input  1  decoded instruction writes the register file.
REQ-009 dec_ret  input  1  decoded instruction is RET.
REQ-010 lsu_done  input  1  LSU reply; sampled only in WAIT.
REQ-011 next_pc  input  PC_WIDTH  PC computed by the PC unit; captured in UPDATE.
REQ-012 core_state  output  3  state code; drives the core_state input of regfile.
REQ-013 pc  output  PC_WIDTH  current program counter.
REQ-014 fetch_req  output  1  fetch request to the fetcher.
REQ-015 lsu_req  output  1  single-cycle LSU launch pulse.
REQ-016 reg_write_enable  output  1  regfile write strobe.
REQ-017 done  output  1  thread finished.
REQ-018 error  output  1  LSU timeout occurred; sticky.

Function
REQ-019 SHALL encode states as IDLE=000, FETCH=001, DECODE=010, REQUEST=011, WAIT=100, EXECUTE=101, UPDATE=110, DONE=111, and drive core_state as a registered copy of the current state.
REQ-020 IDLE: start=1 -> FETCH on the next edge; otherwise hold.
REQ-021 FETCH: fetch_req=1 combinationally for every cycle in FETCH; fetch_done=1 -> DECODE, including when fetch_done is high on the first FETCH cycle.
REQ-022 DECODE -> REQUEST unconditionally after 1 cycle.
REQ-023 REQUEST: 1 cycle (regfile read cycle); latch dec_mem_op into mem_pending; lsu_req=1 for exactly this cycle when dec_mem_op=1; -> WAIT.
REQ-024 WAIT, mem_pending=0 -> EXECUTE after 1 cycle.
REQ-025 WAIT, mem_pending=1 -> EXECUTE on the edge where lsu_done=1; each WAIT cycle with lsu_done=0 increments an 8-bit wait counter that is cleared on WAIT entry.
REQ-026 WAIT, wait counter reaches TIMEOUT with lsu_done=0 -> DONE on the next edge with error=1; lsu_done and TIMEOUT in the same cycle SHALL resolve to EXECUTE, with no error.
REQ-027 lsu_done outside WAIT, and fetch_done outside FETCH, SHALL be ignored and not remembered.
REQ-028 EXECUTE -> UPDATE unconditionally after 1 cycle.
REQ-029 UPDATE: reg_write_enable=dec_reg_we for exactly this cycle; pc <= next_pc at the UPDATE->next edge; dec_ret=1 -> DONE, else -> FETCH.
REQ-030 Whenever dec_ret=1 in UPDATE, pc SHALL still update and a write with dec_reg_we=1 SHALL still occur.
REQ-031 DONE: done=1; hold while start=1; start=0 -> IDLE; error clears only on reset.
REQ-032 start SHALL be ignored in every state except IDLE.
REQ-033 pc SHALL wrap modulo 2^PC_WIDTH as supplied by next_pc; the block performs no PC arithmetic.
REQ-034 reg_write_enable, fetch_req and lsu_req SHALL be 0 in every state other than those stated above.

Reset
REQ-035 reset=0 SHALL asynchronously force state=IDLE, core_state=000, pc=0, the wait counter=0, mem_pending=0, fetch_req=0, lsu_req=0, reg_write_enable=0, done=0, and error=0, regardless of clk.
REQ-036 Reset asserted mid-instruction SHALL abort with no further write strobe; after release, the block SHALL stay in IDLE until start=1.

Verification
REQ-037 ALU instruction: start pulse, fetch_done on the 2nd FETCH cycle, dec_reg_we=1, next_pc=0x01 -> states 001,001,010,011,100,101,110,001; reg_write_enable is high for the single UPDATE cycle; pc=0x01.
REQ-038 Load: dec_mem_op=1, lsu_done after 3 WAIT cycles -> lsu_req is a 1-cycle pulse in REQUEST; 4 cycles in WAIT; then EXECUTE; error=0.
REQ-039 Timeout: dec_mem_op=1, lsu_done held at 0 -> after TIMEOUT cycles, DONE with done=1 and error=1; error stays set after start=0 and the return to IDLE.
REQ-040 RET: dec_ret=1, dec_reg_we=0, next_pc=0x05 -> UPDATE then DONE; pc=0x05; start=0 then IDLE.
REQ-041 Async reset: reset=0 pulsed mid-cycle in WAIT -> all outputs are zero before the next clk edge; start is ignored until reset=1.
REQ-042 Spurious inputs: lsu_done pulsed in DECODE and start pulsed in EXECUTE -> no state deviation; a later memory instruction still waits for its own lsu_done.
